// File: rtl/gray_arb_pkg.sv
// Shared types and Gray-code conversion helpers for the shared converter arbiter.
package gray_arb_pkg;

    // Helpers work on zero-extended words up to this width; callers truncate the result.
    localparam int unsigned CONV_MAX_W = 64;

    typedef enum logic {
        DIR_B2G = 1'b0,
        DIR_G2B = 1'b1
    } dir_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic [CONV_MAX_W-1:0] bin2gray(input logic [CONV_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits propagate as zero, so the low WIDTH bits match a WIDTH-bit conversion.
    function automatic logic [CONV_MAX_W-1:0] gray2bin(input logic [CONV_MAX_W-1:0] g);
        logic [CONV_MAX_W-1:0] b;
        b                = '0;
        b[CONV_MAX_W-1]  = g[CONV_MAX_W-1];
        for (int k = CONV_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin grant search starting at a pointer; purely combinational.
module rr_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [ID_W-1:0]    idx_c_o,
    output logic               any_c_o
);

    logic [ID_W-1:0] cand_c;

    // Walk candidates ptr, ptr+1, ... modulo NUM_REQ and take the first valid one.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand_c  = '0;
        if (en_i) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                cand_c = ID_W'((32'(ptr_i) + off) % NUM_REQ);
                if (!any_c_o && req_i[cand_c]) begin
                    any_c_o         = 1'b1;
                    gnt_c_o[cand_c] = 1'b1;
                    idx_c_o         = cand_c;
                end
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one Gray-code converter among NUM_REQ requesters with round-robin grant
// and a single back-pressurable, ID-tagged result register.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int unsigned WIDTH   = 4,
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_dir,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_dir,
    output logic                     busy
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;
    dir_e                  out_dir_q, out_dir_d;

    logic                  can_accept_c;
    logic                  arb_en_c;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [ID_W-1:0]       gnt_idx_c;
    logic                  gnt_any_c;
    logic [WIDTH-1:0]      sel_word_c;
    dir_e                  sel_dir_c;
    logic [WIDTH-1:0]      conv_word_c;

    // Grants are blocked while reset is asserted so no transfer is acknowledged then.
    assign can_accept_c = (state_q == ST_EMPTY) | out_ready;
    assign arb_en_c     = can_accept_c & ~rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .en_i    (arb_en_c),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (gnt_c),
        .idx_c_o (gnt_idx_c),
        .any_c_o (gnt_any_c)
    );

    // One-hot select of the granted word and direction.
    always_comb begin
        sel_word_c = '0;
        sel_dir_c  = DIR_B2G;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                sel_word_c = req_data[i*WIDTH +: WIDTH];
                sel_dir_c  = dir_e'(req_dir[i]);
            end
        end
    end

    always_comb begin
        if (sel_dir_c == DIR_G2B) begin
            conv_word_c = WIDTH'(gray2bin(CONV_MAX_W'(sel_word_c)));
        end else begin
            conv_word_c = WIDTH'(bin2gray(CONV_MAX_W'(sel_word_c)));
        end
    end

    // Next state: a grant always fills the result register; otherwise drain on out_ready.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_dir_d  = out_dir_q;
        if (gnt_any_c) begin
            state_d    = ST_FULL;
            out_data_d = conv_word_c;
            out_id_d   = gnt_idx_c;
            out_dir_d  = sel_dir_c;
            rr_ptr_d   = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
        end else begin
            case (state_q)
                ST_FULL:  if (out_ready) state_d = ST_EMPTY;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            out_dir_q  <= DIR_B2G;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_dir_q  <= out_dir_d;
        end
    end

    assign req_ready = gnt_c;
    assign out_valid = (state_q == ST_FULL);
    assign busy      = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_dir   = out_dir_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus randomized traffic
// against a behavioural round-robin / conversion model.
module tb_gray_conv_arbiter;

    localparam int unsigned W = 4;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_dir;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_dir;
    logic           busy;

    int nvec = 0;
    int nerr = 0;
    logic [W-1:0] last_exp;

    // Model state
    bit           m_full;
    int           m_ptr;
    logic [W-1:0] m_data;
    int           m_id;
    logic         m_dir;

    gray_conv_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_dir   (out_dir),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Gray->binary as XOR of all right shifts; binary->Gray as b ^ (b>>1).
    function automatic logic [W-1:0] ref_conv(input logic [W-1:0] w, input logic d);
        logic [W-1:0] r;
        if (!d) begin
            r = w ^ (w >> 1);
        end else begin
            r = '0;
            for (int k = 0; k < int'(W); k++) r = r ^ (w >> k);
        end
        return r;
    endfunction

    function automatic int model_grant();
        if (rst || !(!m_full || out_ready)) return -1;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_apply(input int g);
        if (rst) begin
            m_full = 0; m_ptr = 0; m_data = '0; m_id = 0; m_dir = 1'b0;
        end else if (g >= 0) begin
            m_data = ref_conv(req_data[g*W +: W], req_dir[g]);
            m_id   = g;
            m_dir  = req_dir[g];
            m_ptr  = (g + 1) % int'(N);
            m_full = 1;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'hF; req_dir = 4'h5; req_data = 16'hA5C3; out_ready = 1'b0;
        tick; tick;
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", out_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (out_data !== 4'b0000) begin nerr++; $display("FAIL reset_data got %b want 0000", out_data); end
        nvec++; if (out_id !== 2'd0) begin nerr++; $display("FAIL reset_id got %0d want 0", out_id); end
        nvec++; if (out_dir !== 1'b0) begin nerr++; $display("FAIL reset_dir got %b want 0", out_dir); end
        rst = 1'b0; req_valid = '0;
        tick;
    endtask

    task automatic test_basic;
        req_valid = 4'b0100; req_dir = 4'b0000; req_data = 16'h0500; out_ready = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL basic_ready got %b want 0100", req_ready); end
        tick;
        req_valid = '0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 4'b0111) begin nerr++; $display("FAIL basic_data got %b want 0111", out_data); end
        nvec++; if (out_id !== 2'd2) begin nerr++; $display("FAIL basic_id got %0d want 2", out_id); end
        nvec++; if (out_dir !== 1'b0) begin nerr++; $display("FAIL basic_dir got %b want 0", out_dir); end
    endtask

    task automatic test_g2b;
        req_valid = 4'b0010; req_dir = 4'b0010; req_data = 16'h00F0; out_ready = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL g2b_ready0 got %b want 0010", req_ready); end
        tick;
        req_data = 16'h0060;
        nvec++; if (out_data !== 4'b1010) begin nerr++; $display("FAIL g2b_data0 got %b want 1010", out_data); end
        nvec++; if (out_id !== 2'd1) begin nerr++; $display("FAIL g2b_id0 got %0d want 1", out_id); end
        nvec++; if (out_dir !== 1'b1) begin nerr++; $display("FAIL g2b_dir0 got %b want 1", out_dir); end
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL g2b_ready1 got %b want 0010", req_ready); end
        tick;
        req_valid = '0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL g2b_valid1 got %b want 1", out_valid); end
        nvec++; if (out_data !== 4'b0100) begin nerr++; $display("FAIL g2b_data1 got %b want 0100", out_data); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        logic [W-1:0] exp_d;
        rst = 1'b1; req_valid = '0; tick; rst = 1'b0;
        req_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_data = 16'($urandom); req_dir = 4'($urandom);
            exp_gnt = 4'b0001 << (k % 4);
            exp_d   = ref_conv(req_data[(k%4)*W +: W], req_dir[k%4]);
            #1;
            nvec++; if (req_ready !== exp_gnt) begin nerr++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_gnt); end
            tick;
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rr_valid[%0d] got %b want 1", k, out_valid); end
            nvec++; if (out_id !== 2'(k % 4)) begin nerr++; $display("FAIL rr_id[%0d] got %0d want %0d", k, out_id, k % 4); end
            nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL rr_data[%0d] got %b want %b", k, out_data, exp_d); end
            last_exp = exp_d;
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] exp_d;
        out_ready = 1'b0; req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            req_data = 16'($urandom); req_dir = 4'($urandom);
            #1;
            nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL bp_ready[%0d] got %b want 0000", k, req_ready); end
            tick;
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid[%0d] got %b want 1", k, out_valid); end
            nvec++; if (out_id !== 2'd1) begin nerr++; $display("FAIL bp_id[%0d] got %0d want 1", k, out_id); end
            nvec++; if (out_data !== last_exp) begin nerr++; $display("FAIL bp_data[%0d] got %b want %b", k, out_data, last_exp); end
        end
        out_ready = 1'b1;
        exp_d = ref_conv(req_data[2*W +: W], req_dir[2]);
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL bp_release_ready got %b want 0100", req_ready); end
        tick;
        req_valid = '0;
        nvec++; if (out_id !== 2'd2) begin nerr++; $display("FAIL bp_release_id got %0d want 2", out_id); end
        nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL bp_release_data got %b want %b", out_data, exp_d); end
        tick;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_wrap;
        req_valid = 4'b0001; req_dir = 4'b0000; req_data = 16'h000F; out_ready = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
        tick;
        req_data = 16'h0000;
        nvec++; if (out_data !== 4'b1000) begin nerr++; $display("FAIL wrap_data0 got %b want 1000", out_data); end
        nvec++; if (out_id !== 2'd0) begin nerr++; $display("FAIL wrap_id got %0d want 0", out_id); end
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_ready1 got %b want 0001", req_ready); end
        tick;
        req_valid = '0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL wrap_valid1 got %b want 1", out_valid); end
        nvec++; if (out_data !== 4'b0000) begin nerr++; $display("FAIL wrap_data1 got %b want 0000", out_data); end
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b0010; req_dir = 4'b0000; req_data = 16'h00B0; out_ready = 1'b1;
        tick;
        req_valid = 4'b1001; out_ready = 1'b0; rst = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
        tick;
        rst = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got %b want 0", busy); end
        nvec++; if (out_data !== 4'b0000) begin nerr++; $display("FAIL rstmid_data got %b want 0000", out_data); end
        out_ready = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL rstmid_grant got %b want 0001", req_ready); end
        tick;
        req_valid = '0;
        nvec++; if (out_id !== 2'd0) begin nerr++; $display("FAIL rstmid_id got %0d want 0", out_id); end
    endtask

    task automatic test_random;
        int g;
        logic [N-1:0] exp_gnt;
        rst = 1'b1; req_valid = '0; tick;
        model_apply(-1);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom); req_dir = 4'($urandom); req_data = 16'($urandom);
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 50) == 0;
            #1;
            g = model_grant();
            exp_gnt = (g < 0) ? 4'b0000 : (4'b0001 << g);
            nvec++; if (req_ready !== exp_gnt) begin nerr++; $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, exp_gnt); end
            tick;
            model_apply(g);
            nvec++; if (out_valid !== m_full) begin nerr++; $display("FAIL rand_valid[%0d] got %b want %b", c, out_valid, m_full); end
            nvec++; if (busy !== m_full) begin nerr++; $display("FAIL rand_busy[%0d] got %b want %b", c, busy, m_full); end
            if (m_full) begin
                nvec++; if (out_data !== m_data) begin nerr++; $display("FAIL rand_data[%0d] got %b want %b", c, out_data, m_data); end
                nvec++; if (out_id !== 2'(m_id)) begin nerr++; $display("FAIL rand_id[%0d] got %0d want %0d", c, out_id, m_id); end
                nvec++; if (out_dir !== m_dir) begin nerr++; $display("FAIL rand_dir[%0d] got %b want %b", c, out_dir, m_dir); end
            end
        end
        rst = 1'b0; req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_dir = '0; req_data = '0; out_ready = 1'b0;
        last_exp = '0;
        test_reset;
        test_basic;
        test_g2b;
        test_round_robin;
        test_backpressure;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
